mario_left_right_mover: RTL and testbench

Horizontal-motion FSM for Mario, ticking on `movement_clock`. It turns the `move_left` / `move_right` button levels into a registered `mario_x` with a three-step speed ramp and tile-based wall collision against the 12×17 `background` map. `mario_x` feeds the vertical mover directly (its column probes). This block consumes that mover's `mario_y` for its row probes.

---
 rtl/mario_pkg.sv | 67 ++++++
 rtl/mario_left_right_mover_if.sv | 30 +++
 rtl/mario_tile_probe.sv | 32 +++
 rtl/mario_left_right_mover.sv | 109 ++++++++++
 tb/tb_mario_left_right_mover.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mario_pkg.sv
// Shared tile codes, screen geometry and state type for Mario's movers.
package mario_pkg;

    // Tile codes stored in the background map
    localparam logic [7:0] BDR = 8'd0;
    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [7:0] GND = 8'd3;
    localparam logic [7:0] TKN = 8'd4;
    localparam logic [7:0] CK1 = 8'd5;
    localparam logic [7:0] CK2 = 8'd6;

    // Geometry in pixels
    localparam int CHARACTER_WIDTH = 42;
    localparam int SCREEN_WIDTH    = 640;
    localparam int BLOCK_WIDTH     = 40;
    localparam int START_X         = 80;
    localparam int X_MAX           = SCREEN_WIDTH - CHARACTER_WIDTH;
    localparam int MAP_ROWS        = 12;
    localparam int MAP_COLS        = 17;

    // Speed ramp: ticks per pixel for each stage, and pixels per stage
    localparam logic [2:0] SLOW_PERIOD  = 3'd4;
    localparam logic [2:0] MID_PERIOD   = 3'd2;
    localparam logic [2:0] FAST_PERIOD  = 3'd1;
    localparam logic [6:0] RAMP_PIXELS  = 7'd32;
    localparam logic [6:0] RUN_PIX_MAX  = 7'd64;

    typedef logic [11:0][16:0][7:0] tile_map_t;

    typedef enum logic [1:0] {
        RESET,
        STATIONARY,
        MOVING_LEFT,
        MOVING_RIGHT
    } h_state_t;

    // A probe that falls outside the map reads as border so Mario cannot leave it
    function automatic logic [7:0] tile_at(tile_map_t map, int row, int col);
        logic [7:0] code;
        code = BDR;
        if (row >= 0 && row < MAP_ROWS && col >= 0 && col < MAP_COLS)
            code = map[row[3:0]][col[4:0]];
        return code;
    endfunction

    function automatic logic is_blocking(logic [7:0] code);
        logic blocks;
        case (code)
            BDR, BLK, GND, CK1, CK2: blocks = 1'b1;
            SKY, TKN:                blocks = 1'b0;
            default:                 blocks = 1'b0;
        endcase
        return blocks;
    endfunction

    function automatic int clamp_x(int x);
        int result;
        result = x;
        if (x < 0)
            result = 0;
        else if (x > X_MAX)
            result = X_MAX;
        return result;
    endfunction

endpackage

// File: rtl/mario_left_right_mover_if.sv
// Button, map and position signals between the game logic and the horizontal mover.
interface mario_left_right_mover_if;
    import mario_pkg::*;

    logic      move_left;
    logic      move_right;
    tile_map_t background;
    int        mario_y;
    int        mario_x;
    logic      facing_left;

    modport master (
        output move_left,
        output move_right,
        output background,
        output mario_y,
        input  mario_x,
        input  facing_left
    );

    modport slave (
        input  move_left,
        input  move_right,
        input  background,
        input  mario_y,
        output mario_x,
        output facing_left
    );

endinterface

// File: rtl/mario_tile_probe.sv
// Combinational wall detection: looks at the tiles just left and right of Mario's box.
module mario_tile_probe
    import mario_pkg::*;
(
    input  tile_map_t background,
    input  int        mario_x,
    input  int        mario_y,
    output logic      left_blocked,
    output logic      right_blocked
);

    int top_row;
    int bot_row;
    int lcol;
    int rcol;

    // Probe the top and bottom rows of the sprite one column beyond each side
    always_comb begin
        top_row = (mario_y + 1) / BLOCK_WIDTH;
        bot_row = (mario_y - 1 + CHARACTER_WIDTH) / BLOCK_WIDTH;
        lcol    = (mario_x - 1) / BLOCK_WIDTH;
        rcol    = (mario_x + CHARACTER_WIDTH) / BLOCK_WIDTH;

        left_blocked  = is_blocking(tile_at(background, top_row, lcol)) ||
                        is_blocking(tile_at(background, bot_row, lcol)) ||
                        (mario_x <= 0);
        right_blocked = is_blocking(tile_at(background, top_row, rcol)) ||
                        is_blocking(tile_at(background, bot_row, rcol)) ||
                        (mario_x >= X_MAX);
    end

endmodule

// File: rtl/mario_left_right_mover.sv
// Horizontal motion FSM for Mario with a three-stage speed ramp and tile collision.
module mario_left_right_mover
    import mario_pkg::*;
(
    input logic                     movement_clock,
    input logic                     reset,
    mario_left_right_mover_if.slave bus
);

    h_state_t   state;
    int         x_q;
    logic       facing_q;
    logic [2:0] tick_cnt;
    logic [6:0] run_pix;

    logic       left_blocked;
    logic       right_blocked;
    logic       req_left;
    logic       req_right;
    logic [2:0] period;
    logic       dir_blocked;
    logic       step_now;
    logic       stay_moving;
    int         next_x;

    mario_tile_probe u_probe (
        .background    (bus.background),
        .mario_x       (x_q),
        .mario_y       (bus.mario_y),
        .left_blocked  (left_blocked),
        .right_blocked (right_blocked)
    );

    // Decode the button request, the current ramp stage and whether this tick moves a pixel
    always_comb begin
        req_left  = bus.move_left & ~bus.move_right;
        req_right = bus.move_right & ~bus.move_left;

        if (run_pix < RAMP_PIXELS)
            period = SLOW_PERIOD;
        else if (run_pix < RUN_PIX_MAX)
            period = MID_PERIOD;
        else
            period = FAST_PERIOD;

        dir_blocked = (state == MOVING_LEFT) ? left_blocked : right_blocked;
        step_now    = ((state == MOVING_LEFT) || (state == MOVING_RIGHT)) &&
                      !dir_blocked && (tick_cnt == period - 3'd1);
        stay_moving = (state == MOVING_LEFT) ? (req_left && !left_blocked)
                                             : (req_right && !right_blocked);
        next_x      = (state == MOVING_LEFT) ? clamp_x(x_q - 1) : clamp_x(x_q + 1);
    end

    // State, position, orientation and ramp counters all advance together on the movement tick
    always_ff @(posedge movement_clock or posedge reset) begin
        if (reset) begin
            state    <= RESET;
            x_q      <= START_X;
            facing_q <= 1'b0;
            tick_cnt <= '0;
            run_pix  <= '0;
        end else begin
            case (state)
                RESET: begin
                    state    <= STATIONARY;
                    tick_cnt <= '0;
                    run_pix  <= '0;
                end
                STATIONARY: begin
                    tick_cnt <= '0;
                    run_pix  <= '0;
                    if (req_left && !left_blocked) begin
                        state    <= MOVING_LEFT;
                        facing_q <= 1'b1;
                    end else if (req_right && !right_blocked) begin
                        state    <= MOVING_RIGHT;
                        facing_q <= 1'b0;
                    end
                end
                MOVING_LEFT, MOVING_RIGHT: begin
                    if (step_now)
                        x_q <= next_x;
                    if (stay_moving) begin
                        if (step_now) begin
                            tick_cnt <= '0;
                            if (run_pix != RUN_PIX_MAX)
                                run_pix <= run_pix + 7'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 3'd1;
                        end
                    end else begin
                        state    <= STATIONARY;
                        tick_cnt <= '0;
                        run_pix  <= '0;
                    end
                end
                default: begin
                    state    <= STATIONARY;
                    tick_cnt <= '0;
                    run_pix  <= '0;
                end
            endcase
        end
    end

    assign bus.mario_x     = x_q;
    assign bus.facing_left = facing_q;

endmodule

// File: tb/tb_mario_left_right_mover.sv
// Bench for the horizontal mover: a table of hand-derived vectors, directed corner
// sequences, and random button/map traffic checked tick by tick against a model.
module tb_mario_left_right_mover;

    localparam int T_SKY = 1;
    localparam int T_BLK = 2;
    localparam int XMAX  = 640 - 42;

    logic clk;
    logic reset;
    logic [11:0][16:0][7:0] map;
    int   cur_y;

    int checks;
    int passed;

    // Model state: direction of travel (-1/0/+1), ticks spent on the current pixel,
    // pixels covered in this run, and a flag for the one idle tick after reset
    int   m_x;
    logic m_face;
    int   m_dir;
    int   m_since;
    int   m_pix;
    logic m_boot;

    typedef struct {
        logic l;
        logic r;
        int   ticks;
        int   exp_x;
        logic exp_face;
    } vec_t;

    vec_t vecs[14];

    mario_left_right_mover_if bus ();

    assign bus.background = map;
    assign bus.mario_y    = cur_y;

    mario_left_right_mover dut (
        .movement_clock (clk),
        .reset          (reset),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic tile_blocks(int row, int col);
        logic [7:0] t;
        t = map[row[3:0]][col[4:0]];
        return (t == 8'd0) || (t == 8'd2) || (t == 8'd3) || (t == 8'd5) || (t == 8'd6);
    endfunction

    function automatic logic model_left_blocked(int x);
        int c;
        if (x <= 0)
            return 1'b1;
        c = (x - 1) / 40;
        return tile_blocks((cur_y + 1) / 40, c) || tile_blocks((cur_y + 41) / 40, c);
    endfunction

    function automatic logic model_right_blocked(int x);
        int c;
        if (x >= XMAX)
            return 1'b1;
        c = (x + 42) / 40;
        return tile_blocks((cur_y + 1) / 40, c) || tile_blocks((cur_y + 41) / 40, c);
    endfunction

    task automatic set_tile(input int r, input int c, input int code);
        map[r[3:0]][c[4:0]] = code[7:0];
    endtask

    task automatic fill_map(input int code);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                set_tile(r, c, code);
    endtask

    task automatic model_reset();
        m_x     = 80;
        m_face  = 1'b0;
        m_dir   = 0;
        m_since = 0;
        m_pix   = 0;
        m_boot  = 1'b1;
    endtask

    task automatic model_tick(input logic l, input logic r);
        int   req;
        int   per;
        logic lb;
        logic rb;
        logic blk;
        logic step;
        req = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        lb  = model_left_blocked(m_x);
        rb  = model_right_blocked(m_x);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_dir == 0) begin
            if (req == -1 && !lb) begin
                m_dir  = -1;
                m_face = 1'b1;
            end else if (req == 1 && !rb) begin
                m_dir  = 1;
                m_face = 1'b0;
            end
            m_since = 0;
            m_pix   = 0;
        end else begin
            blk = (m_dir < 0) ? lb : rb;
            per = (m_pix < 32) ? 4 : ((m_pix < 64) ? 2 : 1);
            m_since = m_since + 1;
            step = !blk && (m_since == per);
            if (step) begin
                m_x = m_x + m_dir;
                if (m_x < 0) m_x = 0;
                if (m_x > XMAX) m_x = XMAX;
            end
            if (req == m_dir && !blk) begin
                if (step) begin
                    m_since = 0;
                    m_pix   = (m_pix >= 64) ? 64 : m_pix + 1;
                end
            end else begin
                m_dir   = 0;
                m_since = 0;
                m_pix   = 0;
            end
        end
    endtask

    // Compare the DUT against fixed, hand-derived values
    task automatic checkOutput(input string name, input int ex, input logic ef);
        checks++;
        if (bus.mario_x === ex && bus.facing_left === ef)
            passed++;
        else
            $display("[TB] FAIL %s: mario_x=%0d facing_left=%0b, required mario_x=%0d facing_left=%0b",
                     name, bus.mario_x, bus.facing_left, ex, ef);
    endtask

    // Drive buttons for n ticks, advancing the model and comparing it after every edge
    task automatic applyStimulus(input logic l, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            bus.move_left  = l;
            bus.move_right = r;
            @(posedge clk);
            model_tick(l, r);
            #1;
            checks++;
            if (bus.mario_x === m_x && bus.facing_left === m_face)
                passed++;
            else
                $display("[TB] FAIL model_tick @%0t: mario_x=%0d facing_left=%0b, required mario_x=%0d facing_left=%0b",
                         $time, bus.mario_x, bus.facing_left, m_x, m_face);
        end
    endtask

    task automatic doReset();
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b1;
        cur_y  = 360;
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
        fill_map(T_SKY);

        // Table vectors on an open sky map starting from reset at x=80
        vecs[0]  = '{1'b0, 1'b0,   1,  80, 1'b0};
        vecs[1]  = '{1'b0, 1'b0,   3,  80, 1'b0};
        vecs[2]  = '{1'b0, 1'b1,   5,  81, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 124, 112, 1'b0};
        vecs[4]  = '{1'b0, 1'b1,  64, 144, 1'b0};
        vecs[5]  = '{1'b0, 1'b1,  10, 154, 1'b0};
        vecs[6]  = '{1'b1, 1'b1,   1, 155, 1'b0};
        vecs[7]  = '{1'b1, 1'b1,  50, 155, 1'b0};
        vecs[8]  = '{1'b1, 1'b0,   1, 155, 1'b1};
        vecs[9]  = '{1'b1, 1'b0,   4, 154, 1'b1};
        vecs[10] = '{1'b0, 1'b1,   1, 154, 1'b1};
        vecs[11] = '{1'b0, 1'b1,   1, 154, 1'b0};
        vecs[12] = '{1'b0, 1'b1,   4, 155, 1'b0};
        vecs[13] = '{1'b0, 1'b0,   1, 155, 1'b0};

        doReset();
        checkOutput("reset_state", 80, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].l, vecs[i].r, vecs[i].ticks);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_face);
        end

        // Reset in the middle of a fast run
        doReset();
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 349);
        checkOutput("pre_reset_x300", 300, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("reset_async", 80, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_hold", 80, 1'b0);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("reset_idle_tick", 80, 1'b0);
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("ramp_restart", 81, 1'b0);

        // Brick wall at column 3 across Mario's rows
        fill_map(T_SKY);
        set_tile(9, 3, T_BLK);
        set_tile(10, 3, T_BLK);
        doReset();
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 41);
        checkOutput("wall_back_off", 70, 1'b1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 200);
        checkOutput("wall_stop", 78, 1'b0);

        // Screen edges on an open map
        fill_map(T_SKY);
        doReset();
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 700);
        checkOutput("right_edge", XMAX, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 760);
        checkOutput("left_edge", 0, 1'b1);

        // Random maps, rows and button patterns against the model
        for (int m = 0; m < 3; m++) begin
            for (int r = 0; r < 12; r++)
                for (int c = 0; c < 17; c++)
                    set_tile(r, c, ($urandom_range(0, 9) < 7) ? T_SKY : int'($urandom_range(0, 9)));
            cur_y = int'($urandom_range(0, 398));
            doReset();
            for (int s = 0; s < 30; s++) begin
                if ($urandom_range(0, 3) == 0)
                    cur_y = int'($urandom_range(0, 398));
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(1, 120)));
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
